// File: rtl/gol_gen_timer.sv
// Generation-timing controller for the Game-of-Life grid engine: programmable
// interval, run/pause/single-step, optional ack handshake and a generation limit.
module gol_gen_timer #(
  parameter int CNT_W            = 32,
  parameter int GEN_W            = 16,
  parameter int DEFAULT_INTERVAL = 250000,
  parameter int USE_ACK          = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             step,
  input  logic             interval_wr,
  input  logic [CNT_W-1:0] interval_in,
  input  logic [GEN_W-1:0] gen_limit,
  input  logic             clear_gen,
  input  logic             update_ack,
  output logic             enable_update,
  output logic             busy,
  output logic [GEN_W-1:0] gen_count,
  output logic             limit_hit,
  output logic [CNT_W-1:0] interval_q,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);
  localparam logic [GEN_W-1:0] ONE_G = GEN_W'(1);
  localparam logic [CNT_W-1:0] DEF_C = CNT_W'(DEFAULT_INTERVAL);
  localparam logic             ACK_B = (USE_ACK != 0);

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_counter;
  logic [CNT_W-1:0] w_counter_next;
  logic [CNT_W-1:0] r_interval;
  logic             r_enable;
  logic             w_fire;
  logic             w_complete;
  logic [GEN_W-1:0] r_gen;
  logic [GEN_W-1:0] w_gen_inc;
  logic [GEN_W-1:0] w_gen_next;
  logic             r_limit;
  logic             w_limit_next;

  // Handshake: enable_update is a one-cycle command; update_ack is honoured
  // only in WAIT and never in the same cycle enable_update is high.

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (step && !r_limit) begin
          w_state_next = ACK_B ? S_WAIT : S_IDLE;
        end else if (run && !r_limit) begin
          w_state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!run) begin
          w_state_next = S_IDLE;
        end else if (w_fire) begin
          if (ACK_B) begin
            w_state_next = S_WAIT;
          end else if (w_limit_next) begin
            w_state_next = S_IDLE;
          end
        end
      end
      S_WAIT: begin
        if (!ACK_B) begin
          w_state_next = S_IDLE;
        end else if (w_complete) begin
          w_state_next = (run && !w_limit_next) ? S_COUNT : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // >= rather than == so a lowered interval fires on the very next cycle.
  always_comb begin
    w_fire         = 1'b0;
    w_complete     = 1'b0;
    w_counter_next = r_counter;
    case (r_state)
      S_IDLE: begin
        w_counter_next = '0;
        if (step && !r_limit) begin
          w_fire     = 1'b1;
          w_complete = !ACK_B;
        end
      end
      S_COUNT: begin
        if (!run) begin
          w_counter_next = '0;
        end else if (r_counter >= (r_interval - ONE_C)) begin
          w_fire         = 1'b1;
          w_complete     = !ACK_B;
          w_counter_next = '0;
        end else begin
          w_counter_next = r_counter + ONE_C;
        end
      end
      S_WAIT: begin
        w_counter_next = '0;
        w_complete     = ACK_B && update_ack && !r_enable;
      end
      default: w_counter_next = '0;
    endcase
  end

  always_comb begin
    w_gen_inc    = (r_gen == '1) ? r_gen : (r_gen + ONE_G);
    w_gen_next   = r_gen;
    w_limit_next = r_limit;
    if (clear_gen) begin
      w_gen_next   = '0;
      w_limit_next = 1'b0;
    end else if (w_complete) begin
      w_gen_next = w_gen_inc;
      if ((gen_limit != '0) && (w_gen_inc >= gen_limit)) begin
        w_limit_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_counter  <= '0;
      r_enable   <= 1'b0;
      r_gen      <= '0;
      r_limit    <= 1'b0;
      r_interval <= DEF_C;
    end else begin
      r_counter <= w_counter_next;
      r_enable  <= w_fire;
      r_gen     <= w_gen_next;
      r_limit   <= w_limit_next;
      if (interval_wr) begin
        r_interval <= (interval_in == '0) ? ONE_C : interval_in;
      end
    end
  end

  assign enable_update = r_enable;
  assign busy          = (r_state == S_WAIT);
  assign gen_count     = r_gen;
  assign limit_hit     = r_limit;
  assign interval_q    = r_interval;
  assign dbg_state     = r_state;

endmodule
